// File: rtl/cdc_pkg.sv
// cdc_pkg: shared FSM encoding and counter sizing for the CDC handshake sender
package cdc_pkg;
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO, ABORT} state_t;
  function automatic int cnt_width(input int t);
    return ($clog2(t + 1) < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/cdc_sync_2ff.sv
// cdc_sync_2ff: two-flop level synchroniser with configurable reset value
module cdc_sync_2ff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= INIT;
      r_q    <= INIT;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end
  assign q = r_q;
endmodule

// File: rtl/cdc_hs_sender.sv
// cdc_hs_sender: four-phase request/acknowledge sender with per-phase timeout
module cdc_hs_sender import cdc_pkg::*; #(
  parameter int   DATA_WIDTH     = 8,
  parameter int   TIMEOUT_CYCLES = 1023,
  parameter logic ACK_INIT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_req;
  logic                  r_done;
  logic                  r_tmo;
  logic                  w_ack_s;
  logic                  w_expired;
  logic                  w_take;
  logic                  w_done;
  logic                  w_tmo;
  cdc_sync_2ff #(.INIT(ACK_INIT)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ack_in),
    .q    (w_ack_s)
  );
  assign s_ready     = (r_state == IDLE) && !w_ack_s;
  assign busy        = r_state != IDLE;
  assign w_take      = s_valid && s_ready;
  assign w_expired   = (TIMEOUT_CYCLES > 0) && (r_cnt == TMO);
  assign req_out     = r_req;
  assign data_out    = r_data;
  assign done        = r_done;
  assign timeout_err = r_tmo;
  // acknowledge progress always wins over a coincident expiry
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE:   w_next = w_take ? REQ_HI : IDLE;
      REQ_HI: begin
        w_next = w_ack_s ? REQ_LO : w_expired ? ABORT : REQ_HI;
        w_tmo  = !w_ack_s && w_expired;
      end
      REQ_LO: begin
        w_next = (!w_ack_s || w_expired) ? IDLE : REQ_LO;
        w_done = !w_ack_s;
        w_tmo  = w_ack_s && w_expired;
      end
      default: w_next = w_ack_s ? ABORT : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= w_next == REQ_HI;
      r_done  <= w_done;
      r_tmo   <= w_tmo;
      if (r_state == IDLE && w_take) r_data <= s_data;
      r_cnt   <= (w_next != r_state) ? '0 :
                 ((r_state inside {REQ_HI, REQ_LO}) && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule
